serial_compare_ctrl: RTL and testbench

Sequencing controller that performs a WIDTH-bit magnitude comparison with a single shared 1-bit compare cell. It scans operand bits MSB-first, one bit per cycle, and stops at the first differing bit. It latches a one-hot less/greater/equal result and signals completion with a one-cycle `done` pulse. It sits between a requester (lab top level / stimulus FSM) and the external 1-bit compare cell (inputs A, B, en; outputs AltB, AbtB).

---
 rtl/serial_compare_ctrl.sv | 162 ++++++++++++++++
 tb/tb_serial_compare_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// SerialCompareCtrl (top module serial_compare_ctrl)
//
// This controller compares two WIDTH-bit operands for magnitude using one
// external 1-bit compare cell. It scans the operands from the MSB down, one
// bit per cycle, and stops at the first bit where they differ. The result is
// latched as one-hot less/greater/equal flags, and a one-cycle done pulse
// marks the end of the comparison.
//
// Configuration macro: SERIAL_CMP_SIGNED_EN
//   Defined   - operands are two's complement. On the MSB step the cell's
//               lt/gt outputs are swapped, because the sign bit has the
//               opposite weight.
//   Undefined - unsigned comparison. No swap logic is built.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   comparison request, sampled only while idle
//   a, b     in   WIDTH-bit operands, captured when start is accepted
//   cell_a   out  operand A bit currently presented to the cell
//   cell_b   out  operand B bit currently presented to the cell
//   cell_en  out  cell enable, high only while scanning
//   cell_lt  in   cell A<B output (combinational from cell_a/cell_b/cell_en)
//   cell_gt  in   cell A>B output (combinational)
//   busy     out  high while scanning and in the completion cycle
//   done     out  one-cycle completion pulse
//   a_lt_b   out  latched result: A less than B
//   a_gt_b   out  latched result: A greater than B
//   a_eq_b   out  latched result: A equal to B
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_en,
  input  logic             cell_lt,
  input  logic             cell_gt,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] MSB_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } stateT;

  stateT            state;
  logic [WIDTH-1:0] aQ;
  logic [WIDTH-1:0] bQ;
  logic [IDXW-1:0]  idx;

  logic             bitLt;
  logic             bitGt;
  logic             scanHit;
  logic [IDXW-1:0]  nextIdx;

  // Interpret the cell's answer for the bit currently on the cell.
  // In the signed build the MSB is the sign bit. A 1 there means the operand
  // is smaller, so the lt/gt sense is reversed on that step only.
  // The scan ends on any decisive bit, or after the LSB has been compared
  // equal. When the cell reports lt and gt at the same time (a faulty cell),
  // lt takes priority in the sequential block.
  always_comb begin
    bitLt   = cell_lt;
    bitGt   = cell_gt;
`ifdef SERIAL_CMP_SIGNED_EN
    if (idx == MSB_IDX) begin
      bitLt = cell_gt;
      bitGt = cell_lt;
    end
`endif
    scanHit = bitLt || bitGt || (idx == '0);
    nextIdx = idx - IDXW'(1);
  end

  // Main sequencer. All outputs are registered. The cell drive values are
  // loaded one cycle ahead, so during each SCAN cycle cell_a/cell_b already
  // hold bit idx of the captured operands, and the cell answer can be
  // sampled in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aQ      <= '0;
      bQ      <= '0;
      idx     <= '0;
      cell_a  <= 1'b0;
      cell_b  <= 1'b0;
      cell_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_lt_b  <= 1'b0;
      a_gt_b  <= 1'b0;
      a_eq_b  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            aQ      <= a;
            bQ      <= b;
            idx     <= MSB_IDX;
            cell_en <= 1'b1;
            cell_a  <= a[WIDTH-1];
            cell_b  <= b[WIDTH-1];
            busy    <= 1'b1;
            a_lt_b  <= 1'b0;
            a_gt_b  <= 1'b0;
            a_eq_b  <= 1'b0;
            state   <= SCAN;
          end
        end

        SCAN: begin
          if (scanHit) begin
            a_lt_b  <= bitLt;
            a_gt_b  <= !bitLt && bitGt;
            a_eq_b  <= !bitLt && !bitGt;
            cell_en <= 1'b0;
            cell_a  <= 1'b0;
            cell_b  <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx    <= nextIdx;
            cell_a <= aQ[nextIdx];
            cell_b <= bQ[nextIdx];
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          cell_en <= 1'b0;
          cell_a  <= 1'b0;
          cell_b  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for serial_compare_ctrl (WIDTH=8).
// It models the external 1-bit compare cell and provides a hook that can
// inject a cell fault. The expected results come from whole-word compares
// of the operands. The expected latency comes from the position of the
// highest differing bit.
// ---------------------------------------------------------------------------
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cellA;
  logic         cellB;
  logic         cellEn;
  logic         cellLt;
  logic         cellGt;
  logic         busy;
  logic         done;
  logic         aLtB;
  logic         aGtB;
  logic         aEqB;
  logic         cellFault;

  int total = 0;
  int bad   = 0;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cell_a  (cellA),
    .cell_b  (cellB),
    .cell_en (cellEn),
    .cell_lt (cellLt),
    .cell_gt (cellGt),
    .busy    (busy),
    .done    (done),
    .a_lt_b  (aLtB),
    .a_gt_b  (aGtB),
    .a_eq_b  (aEqB)
  );

  // Behaviour of the external 1-bit cell, with a fault override.
  assign cellLt = cellFault | (cellEn & ~cellA &  cellB);
  assign cellGt = cellFault | (cellEn &  cellA & ~cellB);

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one full comparison. Start is presented in the cycle after "edge 0"
  // and is sampled at edge 1. While the scan runs, start and the operands are
  // scrambled to check that they have no effect.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb);
    logic [W-1:0] diff;
    int           k;
    int           expEdge;
    int           doneEdge;
    logic         expLt;
    logic         expGt;
    logic         expEq;
    diff = ta ^ tb;
    k = -1;
    for (int i = 0; i < W; i++) if (diff[i]) k = i;
    expEdge = (k < 0) ? W + 1 : W - k + 1;
`ifdef SERIAL_CMP_SIGNED_EN
    expLt = ($signed(ta) < $signed(tb));
    expGt = ($signed(ta) > $signed(tb));
`else
    expLt = (ta < tb);
    expGt = (ta > tb);
`endif
    expEq = (ta == tb);

    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    doneEdge = 0;
    for (int e = 1; e <= W + 3 && doneEdge == 0; e++) begin
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      start = 1'($urandom_range(0, 1));
      if (done) begin
        doneEdge = e;
      end else begin
        checkOutput("scanBusy", busy, 1);
        checkOutput("scanCellEn", cellEn, 1);
        checkOutput("scanFlags", {aLtB, aGtB, aEqB}, 0);
        if (e <= W) begin
          checkOutput("traceCellA", cellA, ta[W-e]);
          checkOutput("traceCellB", cellB, tb[W-e]);
        end
      end
    end
    checkOutput("doneEdge", doneEdge, expEdge);
    checkOutput("doneBusy", busy, 1);
    checkOutput("doneCellEn", cellEn, 0);
    checkOutput("ltFlag", aLtB, expLt);
    checkOutput("gtFlag", aGtB, expGt);
    checkOutput("eqFlag", aEqB, expEq);

    // Start may have been high during DONE. It must be ignored there.
    @(negedge clk);
    start = 1'b0;
    checkOutput("pulseOneCycle", done, 0);
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleCellEn", cellEn, 0);
    checkOutput("heldFlags", {aLtB, aGtB, aEqB}, {expLt, expGt, expEq});
  endtask

  // Starts a long (equal-operand) scan and resets it at edge 3.
  task automatic resetMidScan();
    @(negedge clk);
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstAllOutputs",
                {busy, done, cellEn, cellA, cellB, aLtB, aGtB, aEqB}, 0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkOutput("rstNoDone", {done, busy}, 0);
    end
  endtask

  // Drives both cell outputs high during the first SCAN cycle.
  task automatic injectFault();
    @(negedge clk);
    start = 1'b1;
    a     = 8'h3C;
    b     = 8'h3C;
    @(negedge clk);
    start     = 1'b0;
    cellFault = 1'b1;
    @(negedge clk);
    cellFault = 1'b0;
    checkOutput("faultDone", done, 1);
    checkOutput("faultFlags", {aLtB, aGtB, aEqB}, 3'b100);
    @(negedge clk);
    checkOutput("faultDoneLow", done, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cellFault = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetOutputs",
                {busy, done, cellEn, cellA, cellB, aLtB, aGtB, aEqB}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", {busy, done, cellEn}, 0);

    applyStimulus(8'h5A, 8'h5A);
    applyStimulus(8'h80, 8'h7F);
    applyStimulus(8'h12, 8'h13);
    applyStimulus(8'hFE, 8'hFF);
    applyStimulus(8'h00, 8'hFF);
    applyStimulus(8'h7F, 8'h80);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      applyStimulus(ra, rb);
    end

    applyStimulus(8'h12, 8'h13);
    resetMidScan();
    injectFault();
    applyStimulus(8'hA5, 8'hA4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
